decode: RTL
===========

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameters: none; all widths fixed by the 32-bit MIPS datapath.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 if_id_instr  input  32  instruction from IF/ID latch.
REQ-005 if_id_npc  input  32  PC+4 from IF/ID latch.
REQ-006 mem_wb_reg_write  input  1  writeback enable.
REQ-007 mem_wb_write_reg  input  5  writeback destination register.
REQ-008 mem_wb_write_data  input  32  writeback data.
REQ-009 id_ex_wb  output  2  {RegWrite, MemtoReg}.
REQ-010 id_ex_m  output  3  {Branch, MemRead, MemWrite}.
REQ-011 id_ex_ex  output  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-012 id_ex_npc  output  32  registered if_id_npc.
REQ-013 id_ex_readdat1  output  32  registered rs operand.
REQ-014 id_ex_readdat2  output  32  registered rt operand.
REQ-015 id_ex_sign_ext  output  32  registered sign-extended instr[15:0].
REQ-016 id_ex_instr_2016  output  5  registered instr[20:16] (rt).
REQ-017 id_ex_instr_1511  output  5  registered instr[15:11] (rd).

Function
REQ-018 The block SHALL contain a 32 x 32-bit register file, rs = instr[25:21], rt = instr[20:16], reads combinational.
REQ-019 The register file SHALL write mem_wb_write_data to mem_wb_write_reg on a rising edge when mem_wb_reg_write=1 and rst=0.
REQ-020 Register 0 SHALL always read 0; writes to register 0 SHALL be discarded.
REQ-021 Same-cycle write/read to a matching nonzero register SHALL bypass: the ID/EX latch captures mem_wb_write_data, not the stale value (both rs and rt paths).
REQ-022 Control decode by opcode instr[31:26]: 000000 (R) -> wb 10, m 000, ex 1100.
REQ-023 100011 (lw) -> wb 11, m 010, ex 0001.
REQ-024 101011 (sw) -> wb 00, m 001, ex 0001.
REQ-025 000100 (beq) -> wb 00, m 100, ex 0010.
REQ-026 Any other opcode SHALL decode to wb 00, m 000, ex 0000 (bubble).
REQ-027 Sign extension SHALL replicate instr[15] into bits 31:16.
REQ-028 All id_ex_* outputs SHALL be registered: values decoded from inputs present before rising edge N appear after edge N (one-cycle latency), no stall or enable.
REQ-029 Outputs SHALL hold between edges; no output SHALL depend combinationally on inputs.

Reset
REQ-030 rst=1 at a rising edge SHALL clear all id_ex_* outputs to 0 and all 32 registers to 0.
REQ-031 A writeback presented in the same cycle as rst=1 SHALL be discarded.
REQ-032 Reset asserted mid-stream SHALL take effect at the next edge regardless of in-flight instruction; first valid decode appears one edge after rst deasserts.

Verification
REQ-033 Reset: rst=1 two cycles, instr 0x8C240008 applied -> all id_ex_* = 0, regfile reads 0 after release.
REQ-034 R-type: write r1=0x00000005, r2=0x0000000A via WB, then instr 0x00221820, npc 0x00000010 -> readdat1 0x5, readdat2 0xA, 2016=2, 1511=3, wb 10, m 000, ex 1100, npc 0x10.
REQ-035 lw/sw sign extend: 0x8C240008 -> sign_ext 0x00000008, wb 11, m 010, ex 0001; 0xAC22FFFC -> sign_ext 0xFFFFFFFC, wb 00, m 001, ex 0001.
REQ-036 beq and illegal: 0x1022FFFF -> m 100, ex 0010, sign_ext 0xFFFFFFFF; opcode 111111 -> wb/m/ex all 0.
REQ-037 Bypass: same cycle WB r5=0x00001234 and instr with rs=5, rt=5 -> readdat1 = readdat2 = 0x00001234 after that edge.
REQ-038 r0: WB r0=0xDEADBEEF, then instr reading rs=0 -> readdat1 = 0 (also with same-cycle bypass attempt).

Source files
------------

// File: rtl/decode.sv
// ID stage of a 32-bit MIPS pipeline: register file with WB bypass, main control
// decode, sign extension and the ID/EX pipeline latch.
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_id_npc,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_write_reg,
    input  logic [31:0] mem_wb_write_data,
    output logic [1:0]  id_ex_wb,
    output logic [2:0]  id_ex_m,
    output logic [3:0]  id_ex_ex,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_readdat1,
    output logic [31:0] id_ex_readdat2,
    output logic [31:0] id_ex_sign_ext,
    output logic [4:0]  id_ex_instr_2016,
    output logic [4:0]  id_ex_instr_1511
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] sign_ext;
    logic [1:0]  ctl_wb;
    logic [2:0]  ctl_m;
    logic [3:0]  ctl_ex;
    logic        wb_active;

    assign opcode    = if_id_instr[31:26];
    assign rs        = if_id_instr[25:21];
    assign rt        = if_id_instr[20:16];
    assign sign_ext  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign wb_active = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_active) begin
            regs[mem_wb_write_reg] <= mem_wb_write_data;
        end
    end

    // r0 is hardwired; a writeback landing this cycle is forwarded so the latch
    // never captures the stale register contents.
    always_comb begin
        rs_val = regs[rs];
        if (rs == 5'd0) begin
            rs_val = '0;
        end else if (wb_active && (mem_wb_write_reg == rs)) begin
            rs_val = mem_wb_write_data;
        end
    end

    always_comb begin
        rt_val = regs[rt];
        if (rt == 5'd0) begin
            rt_val = '0;
        end else if (wb_active && (mem_wb_write_reg == rt)) begin
            rt_val = mem_wb_write_data;
        end
    end

    always_comb begin
        ctl_wb = 2'b00;
        ctl_m  = 3'b000;
        ctl_ex = 4'b0000;
        case (opcode)
            OP_RTYPE: begin
                ctl_wb = 2'b10;
                ctl_ex = 4'b1100;
            end
            OP_LW: begin
                ctl_wb = 2'b11;
                ctl_m  = 3'b010;
                ctl_ex = 4'b0001;
            end
            OP_SW: begin
                ctl_m  = 3'b001;
                ctl_ex = 4'b0001;
            end
            OP_BEQ: begin
                ctl_m  = 3'b100;
                ctl_ex = 4'b0010;
            end
            default: begin
                ctl_wb = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_wb         <= '0;
            id_ex_m          <= '0;
            id_ex_ex         <= '0;
            id_ex_npc        <= '0;
            id_ex_readdat1   <= '0;
            id_ex_readdat2   <= '0;
            id_ex_sign_ext   <= '0;
            id_ex_instr_2016 <= '0;
            id_ex_instr_1511 <= '0;
        end else begin
            id_ex_wb         <= ctl_wb;
            id_ex_m          <= ctl_m;
            id_ex_ex         <= ctl_ex;
            id_ex_npc        <= if_id_npc;
            id_ex_readdat1   <= rs_val;
            id_ex_readdat2   <= rt_val;
            id_ex_sign_ext   <= sign_ext;
            id_ex_instr_2016 <= if_id_instr[20:16];
            id_ex_instr_1511 <= if_id_instr[15:11];
        end
    end

endmodule
